// File: rtl/addsub_pkg.sv
// Shared encodings for the add/subtract accumulator: command opcodes and FSM states.
package addsub_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/adder_subtractor_with_overflow.sv
// Combinational n-bit adder/subtractor: s = x + y (add_n=0) or x + ~y + 1 (add_n=1),
// with carry-out (no-borrow for subtract) and signed two's-complement overflow.
module adder_subtractor_with_overflow #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         overflow
);

  logic [n-1:0] y_eff;
  logic [n:0]   full;

  // Subtraction reuses the adder: invert the operand and inject the +1 as carry-in.
  assign y_eff = y ^ {n{add_n}};
  assign full  = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};
  assign s     = full[n-1:0];
  assign c_out = full[n];

  // Same-sign effective operands producing a result of the other sign.
  assign overflow = ~(x[n-1] ^ y_eff[n-1]) & (s[n-1] ^ x[n-1]);

endmodule

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator (IDLE -> EXEC -> RESP) around adder_subtractor_with_overflow.
// Optional macro ADDSUB_ACC_SAT_EN saturates acc on ADD/SUB signed overflow.
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [n-1:0] y,
  output logic [n-1:0] acc,
  output logic         c_out,
  output logic         overflow,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [1:0]   state;
  logic [1:0]   op_reg;
  logic [n-1:0] y_reg;
  logic [n-1:0] sum;
  logic [n-1:0] next_acc;
  logic         as_c_out;
  logic         as_overflow;

  adder_subtractor_with_overflow #(.n(n)) u_addsub (
    .x        (acc),
    .y        (y_reg),
    .add_n    (op_reg[0]),
    .s        (sum),
    .c_out    (as_c_out),
    .overflow (as_overflow)
  );

`ifdef ADDSUB_ACC_SAT_EN
  // NOTE: every path assigns next_acc, so this always_comb cannot infer a latch.
  // A nonnegative accumulator can only overflow upward, a negative one downward.
  always_comb begin
    next_acc = sum;
    if (as_overflow)
      next_acc = acc[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
  end
`else
  assign next_acc = sum;
`endif

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_reg   <= OP_ADD;
      y_reg    <= '0;
      acc      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_reg <= op;
            y_reg  <= y;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_reg)
            OP_ADD, OP_SUB: begin
              acc      <= next_acc;
              c_out    <= as_c_out;
              overflow <= overflow | as_overflow;
            end
            OP_LOAD: begin
              acc   <= y_reg;
              c_out <= 1'b0;
            end
            default: begin
              acc      <= '0;
              c_out    <= 1'b0;
              overflow <= 1'b0;
            end
          endcase
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/addsub_accumulator.md
# addsub_accumulator

Sequential accumulator stage that consumes the adder/subtractor datapath. It accepts a stream of operand/command pairs over a valid/ready handshake and applies each one to an internal n-bit accumulator through an instantiated `adder_subtractor_with_overflow`. It presents the result, carry and a sticky signed-overflow flag over a second valid/ready handshake. It sits directly downstream of operand sources (register file, test stimulus) and upstream of any result consumer.

## Interface
- `n`, default 4: accumulator and operand width in bits.

- `clk`  in  1  the single clock for the block.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  command/operand available.
- `in_ready`  out  1  block can accept a command.
- `op`  in  2  command: 2'b00 ADD, 2'b01 SUB, 2'b10 LOAD, 2'b11 CLEAR.
- `y`  in  n  operand. Ignored for CLEAR.
- `acc`  out  n  accumulator value, registered.
- `c_out`  out  1  carry of the last ADD/SUB, registered.
- `overflow`  out  1  sticky signed two's-complement overflow, registered.
- `out_valid`  out  1  result of the last accepted command is presented.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register `op` and `y`, then go to EXEC.
- **EXEC:**
  - `in_ready`=0. The sub-module computes `acc` ± `y_reg`, with `add_n`=`op_reg[0]`.
  - At the clock edge, update registers per command, then go to RESP:
    - ADD/SUB: `acc` ← `s`; `c_out` ← sub-module `c_out`; `overflow` ← `overflow` | sub-module `overflow`.
    - LOAD: `acc` ← `y_reg`; `c_out` ← 0; `overflow` unchanged.
    - CLEAR: `acc` ← 0; `c_out` ← 0; `overflow` ← 0.
- **RESP:**
  - `out_valid`=1 and `in_ready`=0.
  - On `out_ready`=1, go to IDLE. Otherwise hold, with all outputs stable.
- Arithmetic rules:
  - SUB is `acc` + ~`y` + 1.
  - For SUB, `c_out`=1 means no borrow (`acc` ≥ `y` unsigned).
  - Overflow means the operand signs satisfy the overflow condition for the operation and the result sign differs.
- The sticky `overflow` is cleared only by CLEAR or reset.
- `in_valid` is ignored outside IDLE. Commands are never dropped and never double-accepted.

## Timing
- Reset, when `rst_n`=0 at a rising edge:
  - State goes to IDLE; `acc`=0, `c_out`=0, `overflow`=0, `out_valid`=0, internal operand registers=0.
  - `in_ready`=1 from the first cycle after reset.
- Reset mid-operation (EXEC or RESP) aborts the command. No `out_valid` is produced for it.
- Latency:
  - Command accepted at edge T.
  - `acc`, `c_out` and `overflow` are updated at edge T+1.
  - `out_valid`=1 during the cycle after T+1.
  - Earliest next acceptance is at edge T+3, when `out_ready`=1 is held continuously.
- `out_valid` and `in_ready` are decoded from the state register, with no combinational path from inputs.
- Handshake on the same edge: `out_ready`=1 in RESP and `in_valid`=1 take effect in turn. The return to IDLE happens first; the new command is accepted at the next edge.
- Wrap-around: without saturation, `acc` wraps modulo 2^n.

## Configuration
- Macro: `ADDSUB_ACC_SAT_EN`.
- **Defined:** on ADD/SUB overflow, `acc` saturates.
  - Positive overflow gives 2^(n-1)-1.
  - Negative overflow gives -2^(n-1).
  - `c_out` and the sticky `overflow` behave as without the macro.
- **Undefined:** `acc` takes the wrapped sum `s`. No saturation logic is compiled.

## Structure
- Shared package `addsub_pkg`:
  - op encodings `OP_ADD`, `OP_SUB`, `OP_LOAD`, `OP_CLEAR`.
  - FSM state encodings `ST_IDLE`, `ST_EXEC`, `ST_RESP`.
- One sub-module: the existing `adder_subtractor_with_overflow` #(.n(n)).
  - `x`=`acc`, `y`=`y_reg`, `add_n`=`op_reg[0]`.
- FSM, registers and saturation mux live in the top module.

## Test plan
All scenarios use n=4.
- Reset, then ADD 5, ADD 6 → `acc`=5 then 4'd11 (4'b1011); `overflow`=1 (sticky); `c_out`=0; each `out_valid` appears 2 cycles after acceptance.
- LOAD 3, SUB 5 → `acc`=4'b1110 (-2); `c_out`=0 (borrow); `overflow`=0.
- LOAD 7, ADD 1:
  - Without the macro → `acc`=4'b1000, `overflow`=1.
  - With `ADDSUB_ACC_SAT_EN` → `acc`=4'b0111, `overflow`=1.
- LOAD 8, SUB 1:
  - Without the macro → `acc`=4'b0111, `overflow`=1.
  - With the macro → `acc`=4'b1000.
  - Then CLEAR → `acc`=0, `overflow`=0.
- In RESP, hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `out_valid` held, `acc` stable, `in_ready`=0, no command accepted. Then `out_ready`=1 → accept at the following edge.
- Assert `rst_n`=0 during EXEC of ADD 4 with `acc`=2 → next cycle `acc`=0, `out_valid`=0, `in_ready`=1.
